// File: rtl/demux1_2_4bit_stream.sv
// ---------------------------------------------------------------------------
// demux1_2_4bit_stream
//   Routes one valid/ready input stream to one of two output streams, chosen
//   per beat by in_sel (0 -> out1, 1 -> out2). Each output owns a small FIFO
//   so a stalled sink only blocks beats addressed to itself.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_data/in_sel        input beat and its destination
//   in_valid/in_ready     input handshake; in_ready depends only on the
//                         registered full flags and in_sel
//   outN_data/outN_valid  head of FIFO N (data forced to 0 when empty)
//   outN_ready            sink N accepts the head
//   outN_cnt              beats pushed into FIFO N since reset (wrapping)
//   idle                  both FIFOs empty
// ---------------------------------------------------------------------------
module demux1_2_4bit_stream #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [CNT_W-1:0] out1_cnt,
  output logic [CNT_W-1:0] out2_cnt,
  output logic             idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

  // Index 0 is the out1 FIFO, index 1 is the out2 FIFO.
  logic [WIDTH-1:0] mem_q  [2][DEPTH];
  logic [PW-1:0]    wptr_q [2];
  logic [PW-1:0]    wptr_d [2];
  logic [PW-1:0]    rptr_q [2];
  logic [PW-1:0]    rptr_d [2];
  logic [OW-1:0]    occ_q  [2];
  logic [OW-1:0]    occ_d  [2];
  logic [CNT_W-1:0] cnt_q  [2];
  logic [CNT_W-1:0] cnt_d  [2];

  logic [1:0] full_s;
  logic [1:0] valid_s;
  logic [1:0] push_s;
  logic [1:0] pop_s;
  logic [1:0] out_ready_s;

  assign out_ready_s = {out2_ready, out1_ready};

  // Status flags come straight from registered occupancy.
  always_comb begin
    for (int f = 0; f < 2; f++) begin
      full_s[f]  = (occ_q[f] == OCC_FULL);
      valid_s[f] = (occ_q[f] != {OW{1'b0}});
    end
  end

  // Ready looks only at the selected FIFO's full flag: no path from outN_ready.
  assign in_ready = in_sel ? !full_s[1] : !full_s[0];

  // Handshake qualification per FIFO.
  always_comb begin
    push_s[0] = in_valid & !in_sel & !full_s[0];
    push_s[1] = in_valid &  in_sel & !full_s[1];
    for (int f = 0; f < 2; f++) begin
      pop_s[f] = valid_s[f] & out_ready_s[f];
    end
  end

  // Next-state for pointers, occupancy and accepted-beat counters.
  always_comb begin
    for (int f = 0; f < 2; f++) begin
      wptr_d[f] = wptr_q[f];
      rptr_d[f] = rptr_q[f];
      occ_d[f]  = occ_q[f];
      cnt_d[f]  = cnt_q[f];
      if (push_s[f]) begin
        // DEPTH is a power of two, so natural overflow gives modulo wrap.
        wptr_d[f] = wptr_q[f] + PW'(1);
        cnt_d[f]  = cnt_q[f] + CNT_W'(1);
      end else begin
        wptr_d[f] = wptr_q[f];
        cnt_d[f]  = cnt_q[f];
      end
      if (pop_s[f]) begin
        rptr_d[f] = rptr_q[f] + PW'(1);
      end else begin
        rptr_d[f] = rptr_q[f];
      end
      case ({push_s[f], pop_s[f]})
        2'b10:   occ_d[f] = occ_q[f] + OW'(1);
        2'b01:   occ_d[f] = occ_q[f] - OW'(1);
        default: occ_d[f] = occ_q[f];
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < 2; f++) begin
        wptr_q[f] <= {PW{1'b0}};
        rptr_q[f] <= {PW{1'b0}};
        occ_q[f]  <= {OW{1'b0}};
        cnt_q[f]  <= {CNT_W{1'b0}};
      end
    end else begin
      for (int f = 0; f < 2; f++) begin
        wptr_q[f] <= wptr_d[f];
        rptr_q[f] <= rptr_d[f];
        occ_q[f]  <= occ_d[f];
        cnt_q[f]  <= cnt_d[f];
      end
    end
  end

  // FIFO storage; cleared on reset so stale beats can never reappear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < 2; f++) begin
        for (int e = 0; e < DEPTH; e++) begin
          mem_q[f][e] <= {WIDTH{1'b0}};
        end
      end
    end else begin
      for (int f = 0; f < 2; f++) begin
        if (push_s[f]) begin
          mem_q[f][wptr_q[f]] <= in_data;
        end
      end
    end
  end

  assign out1_valid = valid_s[0];
  assign out2_valid = valid_s[1];
  assign out1_data  = valid_s[0] ? mem_q[0][rptr_q[0]] : {WIDTH{1'b0}};
  assign out2_data  = valid_s[1] ? mem_q[1][rptr_q[1]] : {WIDTH{1'b0}};
  assign out1_cnt   = cnt_q[0];
  assign out2_cnt   = cnt_q[1];
  assign idle       = ~|valid_s;

endmodule

// File: tb/tb_demux1_2_4bit_stream.sv
// ---------------------------------------------------------------------------
// tb_demux1_2_4bit_stream
//   Scoreboard bench: accepted beats are queued per destination; a monitor on
//   the falling edge compares every output against the queue-based model.
// ---------------------------------------------------------------------------
module tb_demux1_2_4bit_stream;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out1_data;
  logic       out1_valid;
  logic       out1_ready;
  logic [3:0] out2_data;
  logic       out2_valid;
  logic       out2_ready;
  logic [7:0] out1_cnt;
  logic [7:0] out2_cnt;
  logic       idle;

  demux1_2_4bit_stream dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
    .out1_cnt(out1_cnt), .out2_cnt(out2_cnt), .idle(idle)
  );

  always #5 clk = ~clk;

  // Reference model: a queue per destination is the FIFO content.
  logic [3:0] q1[$];
  logic [3:0] q2[$];
  logic [7:0] m_cnt1 = 8'd0;
  logic [7:0] m_cnt2 = 8'd0;
  int         n_pop1 = 0;
  int         n_cmp  = 0;
  int         n_err  = 0;
  bit         acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare current outputs, then apply the handshakes of the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      bit rdy1, rdy2;
      rdy1 = (q1.size() < DEPTH);
      rdy2 = (q2.size() < DEPTH);
      chk("out1_valid", out1_valid, q1.size() > 0);
      chk("out1_data",  out1_data,  (q1.size() > 0) ? q1[0] : 4'h0);
      chk("out2_valid", out2_valid, q2.size() > 0);
      chk("out2_data",  out2_data,  (q2.size() > 0) ? q2[0] : 4'h0);
      chk("in_ready",   in_ready,   in_sel ? rdy2 : rdy1);
      chk("out1_cnt",   out1_cnt,   m_cnt1);
      chk("out2_cnt",   out2_cnt,   m_cnt2);
      chk("idle",       idle,       (q1.size() == 0) && (q2.size() == 0));
      if (q1.size() > 0 && out1_ready) begin
        void'(q1.pop_front());
        n_pop1++;
      end
      if (q2.size() > 0 && out2_ready) void'(q2.pop_front());
      if (in_valid && !in_sel && rdy1) begin
        q1.push_back(in_data);
        m_cnt1 = m_cnt1 + 8'd1;
      end
      if (in_valid && in_sel && rdy2) begin
        q2.push_back(in_data);
        m_cnt2 = m_cnt2 + 8'd1;
      end
    end
  end

  // One clock: note whether the input handshake fires, end at posedge+1.
  task automatic step();
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  // Present a beat and hold it until accepted (bounded).
  task automatic send(input logic s, input logic [3:0] d, output int tries);
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    tries    = 0;
    do begin
      step();
      tries++;
    end while (!acc && tries < 40);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    int t;
    int p0;
    rst = 1'b1; in_data = 4'h0; in_sel = 1'b0; in_valid = 1'b0;
    out1_ready = 1'b0; out2_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("rst_idle", idle, 1'b1);
    chk("rst_in_ready", in_ready, 1'b1);

    // Single beat to out1, popped next cycle.
    out1_ready = 1'b1;
    send(1'b0, 4'hA, t);
    chk("t2_valid", out1_valid, 1'b1);
    chk("t2_data", out1_data, 4'hA);
    step();
    chk("t2_popped", out1_valid, 1'b0);
    chk("t2_cnt", out1_cnt, 8'd1);
    chk("t2_out2", out2_valid, 1'b0);

    // Stalled out2 fills; out1 still reachable; drain in order.
    out2_ready = 1'b0;
    send(1'b1, 4'h3, t);
    send(1'b1, 4'h5, t);
    in_sel = 1'b1; #1 chk("full2_ready_sel1", in_ready, 1'b0);
    in_sel = 1'b0; #1 chk("full2_ready_sel0", in_ready, 1'b1);
    send(1'b0, 4'hC, t);
    chk("t3_out1_C", out1_data, 4'hC);
    chk("t3_out2_hold", out2_data, 4'h3);
    step();
    out2_ready = 1'b1;
    repeat (4) step();

    // Alternating destinations, data = index.
    for (int i = 0; i < 16; i++) begin
      logic [4:0] iv;
      iv = 5'(i);
      send(iv[0], iv[3:0], t);
    end
    repeat (3) step();
    chk("alt_cnt1", out1_cnt, 8'd10);
    chk("alt_cnt2", out2_cnt, 8'd10);

    // Sustained push+pop on out1: one beat per cycle.
    p0 = n_pop1;
    for (int i = 0; i < 10; i++) begin
      send(1'b0, 4'($urandom), t);
      chk("thru_tries", t, 1);
    end
    repeat (2) step();
    chk("thru_pops", n_pop1 - p0, 10);

    // Counter wrap: 256 more beats into out1.
    for (int i = 0; i < 256; i++) send(1'b0, 4'($urandom), t);
    repeat (2) step();
    chk("wrap_cnt1", out1_cnt, 8'd20);

    // Random traffic with hold-until-accepted producer.
    acc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 1'($urandom);
        in_data  = 4'($urandom);
      end
      out1_ready = 1'($urandom);
      out2_ready = 1'($urandom);
      step();
    end
    in_valid = 1'b0;
    out1_ready = 1'b1; out2_ready = 1'b1;
    repeat (4) step();

    // Fill out2 (and one beat in out1), then reset mid-stream.
    out1_ready = 1'b0; out2_ready = 1'b0;
    send(1'b1, 4'h9, t);
    send(1'b1, 4'h7, t);
    send(1'b0, 4'hE, t);
    in_valid = 1'b1; in_sel = 1'b1; in_data = 4'hF;
    step();
    #2 rst = 1'b1;
    #1;
    chk("mr_out1_valid", out1_valid, 1'b0);
    chk("mr_out1_data", out1_data, 4'h0);
    chk("mr_out2_valid", out2_valid, 1'b0);
    chk("mr_out2_data", out2_data, 4'h0);
    chk("mr_cnt1", out1_cnt, 8'd0);
    chk("mr_cnt2", out2_cnt, 8'd0);
    chk("mr_idle", idle, 1'b1);
    chk("mr_in_ready", in_ready, 1'b1);
    q1.delete(); q2.delete();
    m_cnt1 = 8'd0; m_cnt2 = 8'd0;
    in_valid = 1'b0;
    step(); step();
    #1 rst = 1'b0;
    out1_ready = 1'b1; out2_ready = 1'b1;
    repeat (5) step();
    chk("post_rst_idle", idle, 1'b1);
    send(1'b1, 4'h6, t);
    chk("post_rst_new", out2_data, 4'h6);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
